simple_pipe_driver: RTL and testbench
=====================================

// Module: simple_pipe_driver
// PURPOSE
//   Instruction-side driver for the 4-register add/sub/and pipeline.
//   - Host side: buffers a program of 8-bit instructions; issues them one per cycle on `inst`.
//   - After issue: drains the pipeline with NOPs.
//   - Then reads all 4 registers through the pipeline's RF debug port (dummy_read_rf/dummy_rf_data).
//   - Streams the register values back to the host over a valid/ready dump channel.
// PARAMETERS
//   DEPTH         8   program buffer entries (power of 2, >=2)
//   DRAIN_CYCLES  3   NOP cycles after last issue before RF readback (ID->EX->WB write)
// PORTS
//   clk            in   1  clock; all state updates on posedge
//   rst            in   1  asynchronous reset, active-low
//   host_valid     in   1  host offers host_inst
//   host_inst      in   8  {op[7:6],rs1[5:4],rs2[3:2],rd[1:0]}
//   host_ready     out  1  driver accepts host_inst this cycle
//   run            in   1  single-cycle start pulse
//   busy           out  1  state != IDLE
//   inst           out  8  instruction to pipeline; 8'h00 (NOP) unless issuing
//   dummy_read_rf  out  2  RF debug read index to pipeline
//   dummy_rf_data  in   8  RF debug read data from pipeline (combinational)
//   dump_valid     out  1  dump beat valid
//   dump_idx       out  2  register index of dump beat
//   dump_data      out  8  register value of dump beat
//   dump_ready     in   1  host accepts dump beat
// BEHAVIOUR
//   - Reset values (async on rst low):
//       state=IDLE, buffer empty, drain/dump counters 0
//       inst=8'h00, dump_valid=0, dump_idx=0, dump_data=0, dummy_read_rf=0, busy=0
//   - host_ready = (state==IDLE) && !full.
//   - Load: host_valid&&host_ready writes the entry at the tail, same edge.
//   - FSM:
//       IDLE : emits NOP.
//              run=1 and buffer non-empty -> ISSUE.
//              run=1 and buffer empty     -> DRAIN.
//              Load and run in the same cycle: the load is written; ISSUE includes it.
//       ISSUE: inst = head entry (combinational); one entry consumed per cycle, no stall.
//              After the last entry -> DRAIN.
//              Issue of N entries takes exactly N cycles.
//       DRAIN: inst=NOP for DRAIN_CYCLES cycles, then -> DUMP with idx=0.
//       DUMP : dummy_read_rf=idx.
//              dump_valid=1; dump_data=dummy_rf_data registered on DUMP entry and after each accepted beat.
//              dump_idx/dump_data held stable while dump_valid && !dump_ready.
//              Handshake on idx 3 -> IDLE; otherwise idx+1.
//   - run outside IDLE is ignored; host_valid outside IDLE is not accepted.
//   - Counters: buffer pointers are log2(DEPTH)+1 bits with wrap bit; full/empty from pointer compare.
//   - Reset mid-operation: immediate return to IDLE; buffer contents discarded; no partial dump beat.
//   - inst is combinational from state + head; pipeline samples it at its own clock edge.
// CONFIGURATION
//   SIMPLE_PIPE_DRIVER_REPLAY_EN
//     defined:
//       - Buffer acts as a program store: ISSUE reads entries 0..count-1 without freeing them.
//       - Every run re-issues the same program.
//       - Extra input port prog_clear (1b): in IDLE, empties the store.
//       - host_ready = IDLE && count<DEPTH.
//     undefined:
//       - Buffer is a FIFO; issued entries are freed; no prog_clear port.
// STRUCTURE
//   - Package simple_pipe_pkg:
//       OP_NOP/OP_ADD/OP_SUB/OP_AND (2b), INST_W=8, REG_IDX_W=2, NUM_REGS=4
//       drv_state_t {IDLE, ISSUE, DRAIN, DUMP}
//   - One sub-module, simple_pipe_inst_fifo: DEPTH x 8 buffer with push/pop/full/empty.
//     Under REPLAY_EN it also provides rewind/clear.
//   - The FSM, drain counter and dump logic stay in this module.
// TESTING (RF stub: dummy_rf_data = 8'h10 + dummy_read_rf)
//   1. Load 8'h47, 8'h9B, 8'hE4; pulse run
//      -> inst = 47, 9B, E4 on 3 consecutive cycles, then 3 cycles of 00
//      -> dump beats (0,10) (1,11) (2,12) (3,13); busy falls after the last beat.
//   2. Push 9 words with host_valid held high
//      -> 8 accepted; host_ready=0 after the 8th; 9th word not written.
//   3. Hold dump_ready=0 for 5 cycles at idx 1
//      -> dump_valid=1, dump_idx=1, dump_data=11 held stable throughout; advances on release.
//   4. run with empty buffer
//      -> no ISSUE cycle; inst stays 00; 3 drain cycles; 4 dump beats.
//   5. Assert rst low during DUMP idx 2
//      -> next cycle dump_valid=0, busy=0, host_ready=1, buffer empty.
//   6. REPLAY_EN: load 47, 9B; run twice
//      -> identical inst sequence both times; prog_clear -> run goes straight to DRAIN.

Source files
------------

// File: rtl/simple_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simple_pipe_pkg
// Description : Shared types and constants for the pipeline instruction
//               driver (instruction encoding, register file geometry and
//               driver FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package simple_pipe_pkg;

  // Instruction word layout: {op[7:6], rs1[5:4], rs2[3:2], rd[1:0]}
  localparam int INST_W    = 8;
  localparam int REG_IDX_W = 2;
  localparam int NUM_REGS  = 4;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;
  localparam logic [1:0] OP_AND = 2'd3;

  // A NOP is the all-zero word: op=NOP with every register field zero
  localparam logic [INST_W-1:0] INST_NOP = {OP_NOP, {(INST_W-2){1'b0}}};

  // Index of the final register read back during the dump phase
  localparam logic [REG_IDX_W-1:0] LAST_REG_IDX = REG_IDX_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DUMP  = 2'd3
  } drv_state_t;

endpackage : simple_pipe_pkg
`default_nettype wire

// File: rtl/simple_pipe_inst_fifo.sv
`default_nettype none
// ============================================================================
// Module      : simple_pipe_inst_fifo
// Description : DEPTH x WIDTH instruction buffer. Pointers carry an extra
//               wrap bit so full/empty fall out of a plain pointer compare.
//               With SIMPLE_PIPE_DRIVER_REPLAY_EN defined the buffer acts as
//               a program store: reads do not free entries, rewind_i resets
//               the read pointer and clear_i empties the store.
// Revision    : 1.0 - initial release
// ============================================================================
module simple_pipe_inst_fifo
  import simple_pipe_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = INST_W
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active-low
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
`ifdef SIMPLE_PIPE_DRIVER_REPLAY_EN
  input  logic             rewind_i,
  input  logic             clear_i,
`endif
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             last_o
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ;
  logic [AW-1:0]    wr_addr;
  logic             do_push;
  logic             do_pop;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign occ     = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign last_o  = (occ == PTR_ONE);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

`ifdef SIMPLE_PIPE_DRIVER_REPLAY_EN
  localparam logic [AW:0] PTR_DEPTH = (AW+1)'(DEPTH);

  // Store never wraps: the write pointer is the entry count
  assign full_o  = (wr_ptr_q == PTR_DEPTH);
  // A clear and a push in the same cycle leave the new word as entry 0
  assign wr_addr = clear_i ? '0 : wr_ptr_q[AW-1:0];

  // Next write/read pointers for the program store
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = do_push ? PTR_ONE : '0;
    end else if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (clear_i || rewind_i) begin
      rd_ptr_d = '0;
    end else if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end
`else
  // Same low bits with opposite wrap bits means the writer lapped the reader
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_addr = wr_ptr_q[AW-1:0];

  // Next write/read pointers for the circular FIFO
  always_comb begin
    wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end
`endif

  // Pointer registers; reset discards buffer contents by emptying it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_addr] <= push_data_i;
    end
  end

endmodule : simple_pipe_inst_fifo
`default_nettype wire

// File: rtl/simple_pipe_driver.sv
`default_nettype none
// ============================================================================
// Module      : simple_pipe_driver
// Description : Instruction-side driver for the 4-register add/sub/and
//               pipeline. Buffers a host program, issues it one word per
//               cycle, drains the pipeline with NOPs, reads every register
//               through the RF debug port and streams the values back to
//               the host over a valid/ready channel.
//               Optional build macro: SIMPLE_PIPE_DRIVER_REPLAY_EN (program
//               store that is re-issued on every run, adds prog_clear).
// Revision    : 1.0 - initial release
// ============================================================================
module simple_pipe_driver
  import simple_pipe_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,           // asynchronous, active-low
  input  logic                 host_valid,
  input  logic [INST_W-1:0]    host_inst,
  output logic                 host_ready,
  input  logic                 run,
`ifdef SIMPLE_PIPE_DRIVER_REPLAY_EN
  input  logic                 prog_clear,
`endif
  output logic                 busy,
  output logic [INST_W-1:0]    inst,
  output logic [REG_IDX_W-1:0] dummy_read_rf,
  input  logic [INST_W-1:0]    dummy_rf_data,
  output logic                 dump_valid,
  output logic [REG_IDX_W-1:0] dump_idx,
  output logic [INST_W-1:0]    dump_data,
  input  logic                 dump_ready
);

  localparam int             DCW        = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);
  localparam logic [DCW-1:0] DRAIN_ONE  = DCW'(1);

  drv_state_t           state_q, state_d;
  logic [DCW-1:0]       drain_cnt_q, drain_cnt_d;
  logic [REG_IDX_W-1:0] dump_idx_q, dump_idx_d;
  logic [INST_W-1:0]    dump_data_q, dump_data_d;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic [INST_W-1:0]    fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_last;
  logic                 in_idle;
  logic                 dump_fire;
  logic                 drain_done;

  assign in_idle    = (state_q == IDLE);
  assign host_ready = in_idle && !fifo_full;
  assign fifo_push  = host_valid && host_ready;
  assign fifo_pop   = (state_q == ISSUE);
  assign busy       = !in_idle;
  assign dump_valid = (state_q == DUMP);
  assign dump_fire  = dump_valid && dump_ready;
  assign drain_done = (state_q == DRAIN) && (drain_cnt_q == DRAIN_LAST);
  assign dump_idx   = dump_idx_q;
  assign dump_data  = dump_data_q;

  // The debug port is pointed at the register whose value is captured at
  // the coming edge, so dump_data always pairs with dump_idx.
  assign dummy_read_rf = dump_idx_d;

  simple_pipe_inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W)
  ) u_inst_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (host_inst),
    .pop_i       (fifo_pop),
`ifdef SIMPLE_PIPE_DRIVER_REPLAY_EN
    // Rewind as the final word issues so the next run starts at entry 0
    .rewind_i    ((state_q == ISSUE) && fifo_last),
    .clear_i     (prog_clear && in_idle),
`endif
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .last_o      (fifo_last)
  );

  // FSM next state, drain counter and instruction output
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    inst        = INST_NOP;
    unique case (state_q)
      IDLE: begin
        if (run) begin
          // A word loaded in the same cycle counts towards this run
          state_d     = (!fifo_empty || fifo_push) ? ISSUE : DRAIN;
          drain_cnt_d = '0;
        end
      end
      ISSUE: begin
        inst = fifo_head;
        if (fifo_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_d     = DUMP;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_ONE;
        end
      end
      DUMP: begin
        if (dump_fire && (dump_idx_q == LAST_REG_IDX)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Dump index: starts at 0 and advances once per accepted beat
  always_comb begin
    dump_idx_d = dump_idx_q;
    if (in_idle) begin
      dump_idx_d = '0;
    end else if (dump_fire) begin
      dump_idx_d = (dump_idx_q == LAST_REG_IDX) ? '0 : (dump_idx_q + 1'b1);
    end
  end

  // Dump data: sampled from the debug port on DUMP entry and after each
  // accepted beat (except the final one), otherwise held
  always_comb begin
    dump_data_d = dump_data_q;
    if (drain_done || (dump_fire && (dump_idx_q != LAST_REG_IDX))) begin
      dump_data_d = dummy_rf_data;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      dump_idx_q  <= '0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      dump_idx_q  <= dump_idx_d;
      dump_data_q <= dump_data_d;
    end
  end

endmodule : simple_pipe_driver
`default_nettype wire

// File: tb/tb_simple_pipe_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_simple_pipe_driver
// Description : Self-checking bench for simple_pipe_driver. A queue-based
//               model predicts every output on every cycle; directed tests
//               pin the model with hand-computed literal values.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_simple_pipe_driver;
  import simple_pipe_pkg::*;

  localparam int DEPTH        = 8;
  localparam int DRAIN_CYCLES = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_valid = 1'b0;
  logic [7:0] host_inst  = 8'h00;
  logic       host_ready;
  logic       run = 1'b0;
`ifdef SIMPLE_PIPE_DRIVER_REPLAY_EN
  logic       prog_clear = 1'b0;
`endif
  logic       busy;
  logic [7:0] inst;
  logic [1:0] dummy_read_rf;
  logic [7:0] dummy_rf_data;
  logic       dump_valid;
  logic [1:0] dump_idx;
  logic [7:0] dump_data;
  logic       dump_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // RF stub: register n holds 8'h10 + n
  assign dummy_rf_data = 8'h10 + {6'b0, dummy_read_rf};

  simple_pipe_driver #(
    .DEPTH        (DEPTH),
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .host_valid    (host_valid),
    .host_inst     (host_inst),
    .host_ready    (host_ready),
    .run           (run),
`ifdef SIMPLE_PIPE_DRIVER_REPLAY_EN
    .prog_clear    (prog_clear),
`endif
    .busy          (busy),
    .inst          (inst),
    .dummy_read_rf (dummy_read_rf),
    .dummy_rf_data (dummy_rf_data),
    .dump_valid    (dump_valid),
    .dump_idx      (dump_idx),
    .dump_data     (dump_data),
    .dump_ready    (dump_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_buf : words held by the driver
  // m_seq : inst values still to appear, one per cycle, after a run
  // m_dumping / m_beat : register dump in progress and next register index
  logic [7:0] m_buf[$];
  logic [7:0] m_seq[$];
  bit         m_dumping = 1'b0;
  int         m_beat    = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_buf.delete();
      m_seq.delete();
      m_dumping = 1'b0;
      m_beat    = 0;
    end else if (m_seq.size() != 0) begin
      void'(m_seq.pop_front());
    end else if (m_dumping) begin
      if (dump_ready) begin
        m_beat++;
        if (m_beat == NUM_REGS) begin
          m_dumping = 1'b0;
          m_beat    = 0;
        end
      end
    end else begin
      bit acc;
      acc = host_valid && (m_buf.size() < DEPTH);
`ifdef SIMPLE_PIPE_DRIVER_REPLAY_EN
      if (prog_clear) m_buf.delete();
`endif
      if (acc) m_buf.push_back(host_inst);
      if (run) begin
        m_seq = m_buf;
        for (int k = 0; k < DRAIN_CYCLES; k++) m_seq.push_back(8'h00);
        m_dumping = 1'b1;
        m_beat    = 0;
`ifndef SIMPLE_PIPE_DRIVER_REPLAY_EN
        m_buf.delete();
`endif
      end
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    logic       e_busy, e_valid, e_ready;
    logic [7:0] e_inst;
    if (!rst) begin
      e_busy = 1'b0; e_valid = 1'b0; e_ready = 1'b1; e_inst = 8'h00;
    end else begin
      e_busy  = (m_seq.size() != 0) || m_dumping;
      e_inst  = (m_seq.size() != 0) ? m_seq[0] : 8'h00;
      e_valid = m_dumping && (m_seq.size() == 0);
      e_ready = !e_busy && (m_buf.size() < DEPTH);
    end
    check("mdl_busy",       busy,       e_busy);
    check("mdl_inst",       inst,       e_inst);
    check("mdl_dump_valid", dump_valid, e_valid);
    check("mdl_host_ready", host_ready, e_ready);
    if (e_valid) begin
      check("mdl_dump_idx",  dump_idx,  m_beat);
      check("mdl_dump_data", dump_data, 8'h10 + m_beat);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] w);
    host_valid = 1'b1;
    host_inst  = w;
    step();
    host_valid = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    step();
    run = 1'b0;
  endtask

  task automatic clear_prog();
`ifdef SIMPLE_PIPE_DRIVER_REPLAY_EN
    prog_clear = 1'b1;
    step();
    prog_clear = 1'b0;
`endif
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      step();
      n++;
    end
    check("wait_idle_timeout", busy, 1'b0);
  endtask

  // Observe a run on an empty buffer: 3 NOP cycles then the first dump beat
  task automatic expect_empty_run(input string tag);
    for (int k = 0; k < DRAIN_CYCLES; k++) begin
      @(negedge clk);
      check({tag, "_drain_inst"},  inst,       8'h00);
      check({tag, "_drain_busy"},  busy,       1'b1);
      check({tag, "_drain_valid"}, dump_valid, 1'b0);
    end
    @(negedge clk);
    check({tag, "_first_beat_valid"}, dump_valid, 1'b1);
    check({tag, "_first_beat_idx"},   dump_idx,   2'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got[9];
    logic [7:0] exp1[6];
    int         nb;
    int         guard;
    int         acc;

    exp1 = '{8'h47, 8'h9B, 8'hE4, 8'h00, 8'h00, 8'h00};

    // ---- reset state ----
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_inst",          inst,          8'h00);
    check("rst_busy",          busy,          1'b0);
    check("rst_dump_valid",    dump_valid,    1'b0);
    check("rst_dump_idx",      dump_idx,      2'd0);
    check("rst_dump_data",     dump_data,     8'h00);
    check("rst_dummy_read_rf", dummy_read_rf, 2'd0);
    check("rst_host_ready",    host_ready,    1'b1);
    step();
    rst = 1'b1;
    step();

    // ---- test 1: three-word program ----
    load(8'h47);
    load(8'h9B);
    load(8'hE4);
    pulse_run();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      got[k] = inst;
    end
    for (int k = 0; k < 6; k++) check($sformatf("t1_inst%0d", k), got[k], exp1[k]);
    nb = 0;
    guard = 0;
    while (nb < 4 && guard < 20) begin
      @(negedge clk);
      guard++;
      if (dump_valid) begin
        check($sformatf("t1_beat%0d_idx", nb),  dump_idx,  nb);
        check($sformatf("t1_beat%0d_data", nb), dump_data, 8'h10 + nb);
        nb++;
      end
    end
    check("t1_beat_count",   nb,    4);
    check("t1_beat_latency", guard, 4);
    @(negedge clk);
    check("t1_busy_after", busy, 1'b0);
    step();

    // ---- test 2: overfill with nine words ----
    clear_prog();
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      host_valid = 1'b1;
      host_inst  = 8'h20 + 8'(i);
      @(negedge clk);
      if (host_ready) acc++;
      step();
    end
    host_valid = 1'b0;
    check("t2_ready_when_full", host_ready, 1'b0);
    check("t2_accepted",        acc,        8);
    pulse_run();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      got[k] = inst;
    end
    for (int k = 0; k < 8; k++) check($sformatf("t2_inst%0d", k), got[k], 8'h20 + 8'(k));
    check("t2_ninth_not_written", got[8], 8'h00);
    step();
    wait_idle();

    // ---- tests 4 and 3: empty run, dump stalled at idx 1 ----
    clear_prog();
    pulse_run();
    expect_empty_run("t4");
    step();
    dump_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_stall_valid", dump_valid, 1'b1);
      check("t3_stall_idx",   dump_idx,   2'd1);
      check("t3_stall_data",  dump_data,  8'h11);
      step();
    end
    dump_ready = 1'b1;
    @(negedge clk);
    check("t3_release_idx", dump_idx, 2'd1);
    @(negedge clk);
    check("t3_advance_idx",  dump_idx,  2'd2);
    check("t3_advance_data", dump_data, 8'h12);
    step();
    wait_idle();

    // ---- test 5: reset during dump of register 2 ----
    load(8'h5A);
    pulse_run();
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(dump_valid && dump_idx == 2'd2) && guard < 30);
    check("t5_reach_idx2", dump_idx, 2'd2);
    #1 dump_ready = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_valid",      dump_valid, 1'b0);
    check("t5_rst_busy",       busy,       1'b0);
    check("t5_rst_host_ready", host_ready, 1'b1);
    step();
    rst = 1'b1;
    dump_ready = 1'b1;
    step();
    pulse_run();
    expect_empty_run("t5_after");
    step();
    wait_idle();

`ifdef SIMPLE_PIPE_DRIVER_REPLAY_EN
    // ---- test 6: program replay and clear ----
    clear_prog();
    load(8'h47);
    load(8'h9B);
    for (int r = 0; r < 2; r++) begin
      pulse_run();
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        got[k] = inst;
      end
      check($sformatf("t6_run%0d_inst0", r), got[0], 8'h47);
      check($sformatf("t6_run%0d_inst1", r), got[1], 8'h9B);
      check($sformatf("t6_run%0d_inst2", r), got[2], 8'h00);
      step();
      wait_idle();
    end
    clear_prog();
    pulse_run();
    expect_empty_run("t6_cleared");
    step();
    wait_idle();
`endif

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_simple_pipe_driver
`default_nettype wire
